// File: rtl/acc_datapath.sv
// Operand accumulator with an IDLE/RUN/DONE control FSM.
// Adds or subtracts DEPTH streamed operands, with optional saturation and a sticky overflow flag.
module acc_datapath #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             sat_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] acc_out,
    output logic             ovf,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             ovf_q, ovf_d;
    logic             sub_q, sub_d;
    logic             sat_q, sat_d;

    logic             xfer;
    logic [WIDTH:0]   sum;
    logic             borrow;

    assign xfer   = in_valid && (state_q == S_RUN);
    assign sum    = {1'b0, acc_q} + {1'b0, in_data};
    assign borrow = in_data > acc_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && (addr_q == LAST)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        acc_d  = acc_q;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        sub_d  = sub_q;
        sat_d  = sat_q;
        if ((state_q == S_IDLE) && start) begin
            acc_d  = '0;
            addr_d = '0;
            ovf_d  = 1'b0;
            sub_d  = sub;
            sat_d  = sat_en;
        end else if (xfer) begin
            addr_d = (addr_q == LAST) ? '0 : addr_q + AW'(1);
            if (addr_q == '0) begin
                acc_d = in_data;
            end else if (!sub_q) begin
                acc_d = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (sat_q) acc_d = '1;
                end
            end else begin
                acc_d = acc_q - in_data;
                if (borrow) begin
                    ovf_d = 1'b1;
                    if (sat_q) acc_d = '0;
                end
            end
        end
    end

    // NOTE: the datapath is a handful of flops, so all of it is cleared by reset (no memory here).
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            addr_q <= '0;
            ovf_q  <= 1'b0;
            sub_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
            sub_q  <= sub_d;
            sat_q  <= sat_d;
        end
    end

    assign addr    = addr_q;
    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Scoreboard bench for acc_datapath: a DEPTH=4 instance and a DEPTH=1 instance.
// Expected results come from an integer reference model and are checked on each done pulse.
module tb_acc_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, sub, sat_en, in_valid;
    logic [7:0] in_data;
    logic       in_ready, busy, ovf, done;
    logic [1:0] addr;
    logic [7:0] acc_out;

    logic       d1_start, d1_sub, d1_sat_en, d1_in_valid;
    logic [7:0] d1_in_data;
    logic       d1_in_ready, d1_busy, d1_ovf, d1_done;
    logic [0:0] d1_addr;
    logic [7:0] d1_acc_out;

    acc_datapath #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .sat_en(sat_en),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .addr(addr), .acc_out(acc_out), .ovf(ovf), .done(done)
    );

    acc_datapath #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(d1_start), .sub(d1_sub), .sat_en(d1_sat_en),
        .in_valid(d1_in_valid), .in_data(d1_in_data), .in_ready(d1_in_ready), .busy(d1_busy),
        .addr(d1_addr), .acc_out(d1_acc_out), .ovf(d1_ovf), .done(d1_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t m4, m1;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: first operand loads, each later one adds/subtracts with wrap or clamp.
    function automatic exp_t model(input int ops[4], input int n, input bit s, input bit sat);
        exp_t r;
        int   a;
        bit   o;
        a = ops[0];
        o = 1'b0;
        for (int i = 1; i < n; i++) begin
            if (!s) begin
                a = a + ops[i];
                if (a > 255) begin
                    o = 1'b1;
                    a = sat ? 255 : a - 256;
                end
            end else begin
                if (ops[i] > a) begin
                    o = 1'b1;
                    a = sat ? 0 : a - ops[i] + 256;
                end else begin
                    a = a - ops[i];
                end
            end
        end
        r.acc = 8'(a);
        r.ovf = o;
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb4_unexpected_done: got done=1 expected no pending run");
            end else begin
                m4 = q4.pop_front();
                check("sb4_acc", 32'(acc_out), 32'(m4.acc));
                check("sb4_ovf", 32'(ovf), 32'(m4.ovf));
            end
        end
        if (d1_done) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_unexpected_done: got done=1 expected no pending run");
            end else begin
                m1 = q1.pop_front();
                check("sb1_acc", 32'(d1_acc_out), 32'(m1.acc));
                check("sb1_ovf", 32'(d1_ovf), 32'(m1.ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input int ops[4], input bit s, input bit sat, input int stall, input bit noise);
        exp_t e;
        e = model(ops, 4, s, sat);
        q4.push_back(e);
        start  = 1'b1;
        sub    = s;
        sat_en = sat;
        step();
        start  = noise;
        sub    = ~s;
        sat_en = ~sat;
        check("run_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int k = 0; k < stall; k++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    check("stall_ready", 32'(in_ready), 1);
                    check("stall_addr", 32'(addr), 32'(i));
                    check("stall_acc", 32'(acc_out), 32'(model(ops, i, s, sat).acc));
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = 8'(ops[i]);
            check("xfer_addr", 32'(addr), 32'(i));
            check("xfer_ready", 32'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("done_ready", 32'(in_ready), 0);
        check("done_addr", 32'(addr), 0);
        step();
        start = 1'b0;
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_acc", 32'(acc_out), 32'(e.acc));
        check("idle_ovf", 32'(ovf), 32'(e.ovf));
        step();
        check("hold_acc", 32'(acc_out), 32'(e.acc));
        check("hold_busy", 32'(busy), 0);
    endtask

    task automatic run1(input int op, input bit s, input bit sat);
        exp_t e;
        e.acc = 8'(op);
        e.ovf = 1'b0;
        q1.push_back(e);
        d1_start  = 1'b1;
        d1_sub    = s;
        d1_sat_en = sat;
        step();
        d1_start = 1'b0;
        check("d1_ready", 32'(d1_in_ready), 1);
        check("d1_addr", 32'(d1_addr), 0);
        d1_in_valid = 1'b1;
        d1_in_data  = 8'(op);
        step();
        d1_in_valid = 1'b0;
        check("d1_done", 32'(d1_done), 1);
        check("d1_addr_after", 32'(d1_addr), 0);
        step();
        check("d1_done_low", 32'(d1_done), 0);
        check("d1_acc", 32'(d1_acc_out), 32'(op));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int r[4];
        reset = 1'b0;
        start = 1'b0; sub = 1'b0; sat_en = 1'b0; in_valid = 1'b0; in_data = '0;
        d1_start = 1'b0; d1_sub = 1'b0; d1_sat_en = 1'b0; d1_in_valid = 1'b0; d1_in_data = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_ovf", 32'(ovf), 0);
        reset = 1'b1;
        step();
        check("idle_no_start", 32'(busy), 0);

        run4('{10, 20, 30, 40}, 1'b0, 1'b0, 0, 1'b0);
        check("add_100", 32'(acc_out), 100);
        run4('{200, 100, 0, 0}, 1'b0, 1'b0, 0, 1'b0);
        check("add_wrap_44", 32'(acc_out), 44);
        run4('{200, 100, 0, 0}, 1'b0, 1'b1, 0, 1'b0);
        check("add_sat_255", 32'(acc_out), 255);
        run4('{100, 30, 20, 10}, 1'b1, 1'b0, 0, 1'b0);
        check("sub_40", 32'(acc_out), 40);
        run4('{10, 20, 0, 0}, 1'b1, 1'b0, 0, 1'b0);
        check("sub_wrap_246", 32'(acc_out), 246);
        run4('{10, 20, 0, 0}, 1'b1, 1'b1, 0, 1'b0);
        check("sub_sat_0", 32'(acc_out), 0);
        run4('{10, 20, 30, 40}, 1'b0, 1'b0, 3, 1'b0);
        check("stall_100", 32'(acc_out), 100);
        run4('{5, 6, 7, 8}, 1'b0, 1'b0, 1, 1'b1);
        check("noise_26", 32'(acc_out), 26);

        start = 1'b1; sub = 1'b1; sat_en = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(50 + i);
            step();
        end
        reset = 1'b0; start = 1'b1; in_valid = 1'b1;
        step();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", 32'(addr), 0);
        check("mid_rst_acc", 32'(acc_out), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_done", 32'(done), 0);
        step();
        check("mid_rst_idle", 32'(busy), 0);
        run4('{1, 2, 3, 4}, 1'b0, 1'b0, 0, 1'b0);
        check("post_rst_10", 32'(acc_out), 10);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) r[i] = int'($urandom_range(0, 255));
            run4(r, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        run1(77, 1'b0, 1'b0);
        run1(int'($urandom_range(0, 255)), 1'b1, 1'b1);

        step();
        check("sb_drained", 32'(q4.size() + q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
